clock_display_ctrl: RTL and testbench
=====================================

# clock_display_ctrl

Parametrised HH:MM:SS timekeeper with its own 4-digit multiplexed seven-segment driver, sitting directly under the board top between the debounced push-buttons and the display pins. It extends the fixed binary-hours/minutes clock with a seconds field, a 12/24-hour display mode, and a set-mode state machine that blinks the field being edited. An MM:SS view select and a parametrised clock rate and scan rate are also added.

## Interface
- CLK_HZ, 100_000_000, input clock frequency; must be even and divisible by 4*REFRESH_HZ
- REFRESH_HZ, 1000, full-display scan rate; each digit is driven for CLK_HZ/(4*REFRESH_HZ) cycles
- clk_100Mhz  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; single clock, no other reset
- btn_set  in  1  debounced, synchronous level; rising edge advances set state
- btn_inc  in  1  debounced, synchronous level; rising edge increments the edited field
- mode_12h  in  1  1 = 12-hour display, 0 = 24-hour display (display only; internal time always 24 h)
- view_sec  in  1  1 = show MM:SS while RUN; ignored in set states
- seg  out  [0:6]  segments a..g, active low, registered
- an  out  [3:0]  digit enables, active low, an[3] leftmost (hours tens), registered
- dp  out  1  colon decimal point on digit 2, active low, registered
- pm  out  1  1 when internal hour >= 12, valid in both modes
- blink  out  1  1 Hz square wave, high for the first half of each second

## Operation
- Prescaler: counts 0..CLK_HZ-1; tick = (count == CLK_HZ-1), one cycle wide; blink = (count < CLK_HZ/2).
- Time registers are BCD: hour 00-23, min 00-59, sec 00-59. On tick in RUN: sec+1; 59 -> 00 carries to min; min 59 -> 00 carries to hour; 23:59:59 -> 00:00:00.
- Button edge detect: previous value registered; rise = btn & ~btn_q. Edges detected in every state.
- FSM states: RUN, SET_HRS, SET_MINS.
  - RUN --set rise--> SET_HRS --set rise--> SET_MINS --set rise--> RUN.
  - SET_HRS: inc rise -> hour+1, 23 -> 00, no carry. SET_MINS: inc rise -> min+1, 59 -> 00, no carry to hour.
  - Time does not advance in set states; ticks there are discarded.
  - SET_MINS -> RUN clears sec to 00 and the prescaler to 0.
  - set rise and inc rise in the same cycle: set wins, inc ignored.
- Display mapping: HH:MM by default; MM:SS when view_sec=1 and state RUN.
- 12-hour conversion (display only): hour 00 -> 12, 13-23 -> hour-12, 01-12 unchanged; a hours tens digit of 0 is blanked in 12-hour mode.
- In set states, both digits of the edited field are blanked (seg = 7'b1111111) while blink=0.
- dp: in RUN, lit while blink=1; in set states, lit constantly.
- Digits 0-9 use standard active-low encodings; blank = all ones. Only one an bit is low at a time.

## Timing
- Reset values: state RUN; time 00:00:00; prescaler 0; scan index 0; button history 0; an=4'b1111, seg=7'b1111111, dp=1, pm=0, blink=1 in the cycle after reset.
- Reset mid-operation, including mid-set, returns everything to the reset values on the next edge.
- First tick occurs CLK_HZ cycles after reset deasserts. sec updates on the edge where tick=1.
- A button rise seen at edge N updates the FSM or field at edge N+1; the new value appears on seg one scan-digit slot later at most.
- Scan: the index advances every CLK_HZ/(4*REFRESH_HZ) cycles in the order an[0], an[1], an[2], an[3], wrapping. seg, an and dp are registered, so they lag the scan index by one cycle.
- pm and blink are registered from time and prescaler state with zero added latency.

## Test plan
- CLK_HZ=64, REFRESH_HZ=4: reset, run 64 cycles -> sec=01 and blink high for cycles 0-31; each an bit low for exactly 4 cycles in rotation; only one low at a time.
- Preload 23:59:59 via set mode plus 59 ticks, then one tick -> 00:00:00 with pm 1->0.
- set, 13 inc rises -> hour=13; set, 5 inc -> min=05; set -> RUN with sec=00. With mode_12h=1, display reads " 1:05", pm=1; with mode_12h=0, display reads "13:05".
- In SET_HRS, hold through 3 prescaler periods -> hours digits blank while blink=0, time unchanged, dp constant 0.
- btn_set and btn_inc rise in the same cycle in SET_HRS -> state becomes SET_MINS and hour is unchanged.
- Assert reset in SET_MINS -> next cycle RUN, 00:00:00, an=4'b1111, seg all ones.

Source files
------------

// File: rtl/clock_display_ctrl.sv
// HH:MM:SS BCD timekeeper with a RUN/SET_HRS/SET_MINS set-mode FSM and a
// registered 4-digit multiplexed seven-segment driver (active-low outputs).
module clock_display_ctrl #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic       clk_100Mhz,
  input  logic       reset,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       mode_12h,
  input  logic       view_sec,
  output logic [0:6] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       pm,
  output logic       blink
);

  localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SCAN_DIV = CLK_HZ / (4 * REFRESH_HZ);
  localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [SW-1:0] SCAN_MAX   = SW'(SCAN_DIV - 1);
  localparam logic [3:0]    DIG_BLANK  = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HRS  = 2'd1,
    ST_SET_MINS = 2'd2
  } state_e;

  // Active-low segments, bit 6 = a ... bit 0 = g; any non-decimal code blanks.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // {tens[2:0], ones[3:0]} BCD increment wrapping 59 -> 00.
  function automatic logic [6:0] bcd60_inc(input logic [6:0] v);
    logic [6:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      if (v[6:4] == 3'd5) begin
        r[6:4] = 3'd0;
      end else begin
        r[6:4] = v[6:4] + 3'd1;
      end
    end else begin
      r[6:4] = v[6:4];
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  // {tens[1:0], ones[3:0]} BCD increment wrapping 23 -> 00.
  function automatic logic [5:0] bcd24_inc(input logic [5:0] v);
    logic [5:0] r;
    if (v == 6'h23) begin
      r = 6'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[5:4] + 2'd1, 4'd0};
    end else begin
      r = {v[5:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   scan_cnt_q, scan_cnt_d;
  logic [1:0]      scan_idx_q, scan_idx_d;
  logic            btn_set_q, btn_set_d;
  logic            btn_inc_q, btn_inc_d;
  logic [5:0]      hr_q, hr_d;
  logic [6:0]      min_q, min_d;
  logic [6:0]      sec_q, sec_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;
  logic            pm_q, pm_d;
  logic            blink_q, blink_d;

  logic            set_rise, inc_rise, tick;
  logic            run_en, edit_hrs, edit_mins, hr_inc, min_inc, exit_set;
  logic            sec_step, min_step, hr_step;
  logic [4:0]      hr_bin, hr_disp;
  logic [3:0]      hr_tens, hr_ones;
  logic            mmss;
  logic [3:0]      dig3, dig2, dig1, dig0, cur_dig;

  assign set_rise = btn_set & ~btn_set_q;
  assign inc_rise = btn_inc & ~btn_inc_q;
  assign tick     = (presc_q == PRESC_MAX);

  // FSM next-state: each set-button rise advances one state around the ring.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (set_rise) state_d = ST_SET_HRS;  else state_d = ST_RUN;
      ST_SET_HRS:  if (set_rise) state_d = ST_SET_MINS; else state_d = ST_SET_HRS;
      ST_SET_MINS: if (set_rise) state_d = ST_RUN;      else state_d = ST_SET_MINS;
      default:     state_d = ST_RUN;
    endcase
  end

  // FSM outputs; a set rise masks a simultaneous inc rise.
  always_comb begin
    run_en    = 1'b0;
    edit_hrs  = 1'b0;
    edit_mins = 1'b0;
    hr_inc    = 1'b0;
    min_inc   = 1'b0;
    exit_set  = 1'b0;
    case (state_q)
      ST_RUN: run_en = 1'b1;
      ST_SET_HRS: begin
        edit_hrs = 1'b1;
        hr_inc   = inc_rise & ~set_rise;
      end
      ST_SET_MINS: begin
        edit_mins = 1'b1;
        min_inc   = inc_rise & ~set_rise;
        exit_set  = set_rise;
      end
      default: run_en = 1'b0;
    endcase
  end

  // Prescaler, scan divider and button history next values.
  always_comb begin
    btn_set_d = btn_set;
    btn_inc_d = btn_inc;
    if (exit_set || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (scan_cnt_q == SCAN_MAX) begin
      scan_cnt_d = '0;
      scan_idx_d = scan_idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + SW'(1);
      scan_idx_d = scan_idx_q;
    end
  end

  // Time update: ticks only count in RUN; set-mode increments never carry.
  always_comb begin
    sec_step = run_en & tick;
    min_step = (sec_step & (sec_q == 7'h59)) | min_inc;
    hr_step  = (sec_step & (sec_q == 7'h59) & (min_q == 7'h59)) | hr_inc;
    if (exit_set) begin
      sec_d = 7'h00;
    end else if (sec_step) begin
      sec_d = bcd60_inc(sec_q);
    end else begin
      sec_d = sec_q;
    end
    if (min_step) begin
      min_d = bcd60_inc(min_q);
    end else begin
      min_d = min_q;
    end
    if (hr_step) begin
      hr_d = bcd24_inc(hr_q);
    end else begin
      hr_d = hr_q;
    end
    pm_d    = (hr_d >= 6'h12);
    blink_d = (presc_d < PRESC_HALF);
  end

  // Digit selection: 12-hour conversion, view select and edit-field blinking.
  always_comb begin
    hr_bin = ({3'b000, hr_q[5:4]} * 5'd10) + {1'b0, hr_q[3:0]};
    if (!mode_12h) begin
      hr_disp = hr_bin;
    end else if (hr_bin == 5'd0) begin
      hr_disp = 5'd12;
    end else if (hr_bin > 5'd12) begin
      hr_disp = hr_bin - 5'd12;
    end else begin
      hr_disp = hr_bin;
    end
    if (hr_disp >= 5'd20) begin
      hr_tens = 4'd2;
      hr_ones = 4'(hr_disp - 5'd20);
    end else if (hr_disp >= 5'd10) begin
      hr_tens = 4'd1;
      hr_ones = 4'(hr_disp - 5'd10);
    end else begin
      hr_tens = 4'd0;
      hr_ones = 4'(hr_disp);
    end
    mmss = view_sec & run_en;
    if (mmss) begin
      dig3 = {1'b0, min_q[6:4]};
      dig2 = min_q[3:0];
      dig1 = {1'b0, sec_q[6:4]};
      dig0 = sec_q[3:0];
    end else begin
      if (mode_12h && (hr_tens == 4'd0)) begin
        dig3 = DIG_BLANK;
      end else begin
        dig3 = hr_tens;
      end
      dig2 = hr_ones;
      dig1 = {1'b0, min_q[6:4]};
      dig0 = min_q[3:0];
    end
    if (edit_hrs && !blink_q) begin
      dig3 = DIG_BLANK;
      dig2 = DIG_BLANK;
    end else begin
      dig3 = dig3;
      dig2 = dig2;
    end
    if (edit_mins && !blink_q) begin
      dig1 = DIG_BLANK;
      dig0 = DIG_BLANK;
    end else begin
      dig1 = dig1;
      dig0 = dig0;
    end
    case (scan_idx_q)
      2'd0:    cur_dig = dig0;
      2'd1:    cur_dig = dig1;
      2'd2:    cur_dig = dig2;
      2'd3:    cur_dig = dig3;
      default: cur_dig = DIG_BLANK;
    endcase
    seg_d = seg_enc(cur_dig);
    an_d  = ~(4'b0001 << scan_idx_q);
    if (scan_idx_q == 2'd2) begin
      dp_d = run_en ? ~blink_q : 1'b0;
    end else begin
      dp_d = 1'b1;
    end
  end

  // Control state: FSM, prescaler, scan position and button history.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      state_q    <= ST_RUN;
      presc_q    <= '0;
      scan_cnt_q <= '0;
      scan_idx_q <= 2'd0;
      btn_set_q  <= 1'b0;
      btn_inc_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      scan_cnt_q <= scan_cnt_d;
      scan_idx_q <= scan_idx_d;
      btn_set_q  <= btn_set_d;
      btn_inc_q  <= btn_inc_d;
    end
  end

  // BCD time registers.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      hr_q  <= 6'h00;
      min_q <= 7'h00;
      sec_q <= 7'h00;
    end else begin
      hr_q  <= hr_d;
      min_q <= min_d;
      sec_q <= sec_d;
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      seg_q   <= 7'b1111111;
      an_q    <= 4'b1111;
      dp_q    <= 1'b1;
      pm_q    <= 1'b0;
      blink_q <= 1'b1;
    end else begin
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
      pm_q    <= pm_d;
      blink_q <= blink_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign pm    = pm_q;
  assign blink = blink_q;

endmodule

// File: tb/tb_clock_display_ctrl.sv
// Directed bench for clock_display_ctrl at CLK_HZ=64, REFRESH_HZ=4: each scan
// slot is 4 cycles and a full scan is 16 cycles.
module tb_clock_display_ctrl;

  localparam int BL = 10;

  logic       clk = 1'b0;
  logic       reset, btn_set, btn_inc, mode_12h, view_sec;
  logic [0:6] seg;
  logic [3:0] an;
  logic       dp, pm, blink;

  int checks = 0;
  int errors = 0;
  int presc_ref = 0;
  logic [6:0] cap_seg [4];
  logic       cap_dp [4];

  clock_display_ctrl #(.CLK_HZ(64), .REFRESH_HZ(4)) dut (
    .clk_100Mhz (clk),
    .reset      (reset),
    .btn_set    (btn_set),
    .btn_inc    (btn_inc),
    .mode_12h   (mode_12h),
    .view_sec   (view_sec),
    .seg        (seg),
    .an         (an),
    .dp         (dp),
    .pm         (pm),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input int d);
    logic [6:0] s;
    case (d)
      0: s = 7'b0000001;
      1: s = 7'b1001111;
      2: s = 7'b0010010;
      3: s = 7'b0000110;
      4: s = 7'b1001100;
      5: s = 7'b0100100;
      6: s = 7'b0100000;
      7: s = 7'b0001111;
      8: s = 7'b0000000;
      9: s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; presc_ref mirrors the expected prescaler count after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    presc_ref = (presc_ref == 63) ? 0 : presc_ref + 1;
  endtask

  task automatic press(input logic s, input logic i, input bit clears);
    btn_set = s;
    btn_inc = i;
    step();
    if (clears) presc_ref = 0;
    step();
    btn_set = 1'b0;
    btn_inc = 1'b0;
    step();
    step();
  endtask

  task automatic capture();
    for (int k = 0; k < 4; k++) begin
      cap_seg[k] = 7'bxxxxxxx;
      cap_dp[k]  = 1'bx;
    end
    for (int c = 0; c < 16; c++) begin
      step();
      case (an)
        4'b1110: begin cap_seg[0] = seg; cap_dp[0] = dp; end
        4'b1101: begin cap_seg[1] = seg; cap_dp[1] = dp; end
        4'b1011: begin cap_seg[2] = seg; cap_dp[2] = dp; end
        4'b0111: begin cap_seg[3] = seg; cap_dp[3] = dp; end
        default: ;
      endcase
    end
  endtask

  task automatic chk_disp(input string tag, input int e3, input int e2, input int e1, input int e0);
    check({tag, "_d3"}, 32'(cap_seg[3]), 32'(enc(e3)));
    check({tag, "_d2"}, 32'(cap_seg[2]), 32'(enc(e2)));
    check({tag, "_d1"}, 32'(cap_seg[1]), 32'(enc(e1)));
    check({tag, "_d0"}, 32'(cap_seg[0]), 32'(enc(e0)));
  endtask

  task automatic chk_reset_outputs(input string tag);
    check({tag, "_an"},    32'(an),    32'(4'b1111));
    check({tag, "_seg"},   32'(seg),   32'(7'b1111111));
    check({tag, "_dp"},    32'(dp),    32'(1'b1));
    check({tag, "_pm"},    32'(pm),    32'(1'b0));
    check({tag, "_blink"}, 32'(blink), 32'(1'b1));
  endtask

  initial begin
    logic [3:0] an_exp;
    logic       pb;

    reset = 1'b1; btn_set = 1'b0; btn_inc = 1'b0; mode_12h = 1'b0; view_sec = 1'b1;
    step(); step(); step();
    presc_ref = 0;
    chk_reset_outputs("rst");

    // First second: blink high for counts 0..31, digits rotate every 4 cycles.
    reset = 1'b0;
    for (int k = 1; k < 64; k++) begin
      step();
      check("run_blink", 32'(blink), 32'(presc_ref < 32));
      an_exp = ~(4'b0001 << (((k - 1) / 4) % 4));
      check("run_an", 32'(an), 32'(an_exp));
    end
    step();
    capture();
    chk_disp("sec1", 0, 0, 0, 1);
    check("sec1_dp2", 32'(cap_dp[2]), 32'(1'b0));
    check("sec1_dp0", 32'(cap_dp[0]), 32'(1'b1));
    check("sec1_pm", 32'(pm), 32'(1'b0));

    // Preload 23:59:00, then run 59 seconds to 23:59:59.
    press(1'b1, 1'b0, 1'b0);
    repeat (23) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (59) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    repeat (59 * 64 - 3) step();
    capture();
    chk_disp("pre_roll", 5, 9, 5, 9);
    check("pre_roll_pm", 32'(pm), 32'(1'b1));
    repeat (64 - 16) step();
    check("roll_pm", 32'(pm), 32'(1'b0));
    capture();
    chk_disp("roll_mmss", 0, 0, 0, 0);
    view_sec = 1'b0;
    capture();
    chk_disp("roll_24h", 0, 0, 0, 0);
    mode_12h = 1'b1;
    capture();
    chk_disp("roll_12h", 1, 2, 0, 0);

    // Set 13:05 and check both display modes and the cleared seconds.
    press(1'b1, 1'b0, 1'b0);
    repeat (13) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (5) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    capture();
    chk_disp("t1305_12h", BL, 1, 0, 5);
    check("t1305_pm", 32'(pm), 32'(1'b1));
    mode_12h = 1'b0;
    capture();
    chk_disp("t1305_24h", 1, 3, 0, 5);
    view_sec = 1'b1;
    capture();
    chk_disp("t1305_mmss", 0, 5, 0, 0);

    // Hold in SET_HRS for three seconds: hours blink, minutes steady, colon lit.
    press(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 192; c++) begin
      pb = (presc_ref < 32);
      step();
      check("hold_blink", 32'(blink), 32'(presc_ref < 32));
      case (an)
        4'b0111: check("hold_d3", 32'(seg), 32'(pb ? enc(1) : enc(BL)));
        4'b1011: check("hold_d2", 32'(seg), 32'(pb ? enc(3) : enc(BL)));
        4'b1101: check("hold_d1", 32'(seg), 32'(enc(0)));
        4'b1110: check("hold_d0", 32'(seg), 32'(enc(5)));
        default: check("hold_an", 32'(an), 32'(4'b1110));
      endcase
      check("hold_dp", 32'(dp), 32'(an == 4'b1011 ? 1'b0 : 1'b1));
    end

    // Simultaneous set+inc: move to SET_MINS without touching the hour.
    press(1'b1, 1'b1, 1'b0);
    for (int w = 0; w < 64 && presc_ref != 32; w++) step();
    capture();
    chk_disp("both_btn", 1, 3, BL, BL);

    // Reset from SET_MINS: back to reset outputs, then RUN from 00:00:00.
    reset = 1'b1;
    step();
    presc_ref = 0;
    chk_reset_outputs("mid_rst");
    reset = 1'b0;
    repeat (64) step();
    capture();
    chk_disp("post_rst_mmss", 0, 0, 0, 1);
    view_sec = 1'b0;
    capture();
    chk_disp("post_rst_hhmm", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
